fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries with synchronous flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign pop_ok    = pop && !empty;
    // A pop frees the head slot, so a push into a full buffer is fine that cycle.
    assign push_ok   = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word requests, buffers in-order responses for decode,
// and discards in-flight responses after a redirect.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W-1:0] remaining;
    logic [63:0]      buf_head;
    logic [31:0]      rsp_pc;
    logic             buf_empty, buf_full;
    logic             req_fire, rsp_dec, push, pop, flush;

    assign occupancy = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_dec   = imem_rsp_valid && (outstanding_q != '0);
    assign remaining = outstanding_q - CNT_W'(rsp_dec);
    assign pop       = out_valid && out_ready;
    // Responses return in order, so the oldest in-flight request sits outstanding words behind pc_q.
    assign rsp_pc    = pc_q - {{(30 - CNT_W){1'b0}}, outstanding_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        if (redirect_valid) begin
            drop_d  = remaining;
            state_d = (remaining != '0) ? ST_FLUSH : ST_FETCH;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_FETCH;
                ST_FETCH: state_d = ST_FETCH;
                ST_FLUSH: begin
                    if (imem_rsp_valid && (drop_q != '0)) begin
                        drop_d = drop_q - CNT_W'(1);
                    end
                    if (drop_d == '0) begin
                        state_d = ST_FETCH;
                    end
                end
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        imem_req_valid = (state_q == ST_FETCH) && !redirect_valid
                         && (occupancy < (CNT_W + 1)'(DEPTH));
        push           = (state_q == ST_FETCH) && imem_rsp_valid && !redirect_valid;
        flush          = redirect_valid;
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h0000_0003;
        end else if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop),
        .head_data (buf_head),
        .empty     (buf_empty),
        .full      (buf_full),
        .count     (buf_count)
    );

    assign imem_req_addr = pc_q;
    assign out_valid     = !buf_empty;
    assign out_instr     = out_valid ? buf_head[31:0] : NOP_INSTR;
    assign out_pc        = out_valid ? buf_head[63:32] : 32'h0;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && buf_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model on the main instance,
// hand-driven responses on a DEPTH=3 instance for the redirect/handshake corner.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] MEM_OFS = 32'h1000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;
    logic        mem_hold;

    logic        d3_rst, d3_req_valid, d3_req_ready, d3_rsp_valid;
    logic [31:0] d3_req_addr, d3_rsp_data, d3_redirect_pc, d3_out_instr, d3_out_pc;
    logic        d3_redirect_valid, d3_out_valid, d3_out_ready;

    fetch_unit u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    fetch_unit #(.RESET_PC(32'h0000_0200), .DEPTH(3)) u_dut3 (
        .clk            (clk),
        .rst            (d3_rst),
        .imem_req_valid (d3_req_valid),
        .imem_req_addr  (d3_req_addr),
        .imem_req_ready (d3_req_ready),
        .imem_rsp_valid (d3_rsp_valid),
        .imem_rsp_data  (d3_rsp_data),
        .redirect_valid (d3_redirect_valid),
        .redirect_pc    (d3_redirect_pc),
        .out_valid      (d3_out_valid),
        .out_ready      (d3_out_ready),
        .out_instr      (d3_out_instr),
        .out_pc         (d3_out_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // In-order memory: data = addr + MEM_OFS, response consumed two edges after the request.
    logic [31:0] mq_addr[$];
    int          mq_cyc[$];
    int          cyc = 0;
    always @(posedge clk) begin
        if (rst) begin
            mq_addr.delete();
            mq_cyc.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (!mem_hold && mq_addr.size() > 0 && mq_cyc[0] < cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mq_addr[0] + MEM_OFS;
                void'(mq_addr.pop_front());
                void'(mq_cyc.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_cyc.push_back(cyc);
            end
        end
        cyc = cyc + 1;
    end

    logic [31:0] req_log[$];
    logic [63:0] out_log[$];
    logic [31:0] d3_pop_log[$];
    always @(posedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
            if (out_valid && out_ready) out_log.push_back({out_pc, out_instr});
        end
        if (!d3_rst && d3_out_valid && d3_out_ready) d3_pop_log.push_back(d3_out_pc);
    end

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [63:0] out_at(input int i);
        return (i < out_log.size()) ? out_log[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        req_log.delete();
        out_log.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unstable;
        int flush_req;
        rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        out_ready = 1'b1; mem_hold = 1'b0;
        d3_rst = 1'b1; d3_req_ready = 1'b1; d3_rsp_valid = 1'b0; d3_rsp_data = '0;
        d3_redirect_valid = 1'b0; d3_redirect_pc = '0; d3_out_ready = 1'b1;

        // Reset values, then the basic stream 0x0, 0x4, 0x8
        repeat (3) tick();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_out_instr", out_instr, 32'h0000_0013);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_state", 64'(u_dut.state_q), 64'(ST_BOOT));
        check_eq("rst_pc", imem_req_addr, 0);
        rst = 1'b0;
        req_log.delete(); out_log.delete();
        check_eq("boot_no_req", imem_req_valid, 0);
        tick();
        check_eq("first_req_valid", imem_req_valid, 1);
        check_eq("first_req_addr", imem_req_addr, 0);
        for (int i = 0; i < 20 && imem_rsp_valid !== 1'b1; i++) tick();
        check_eq("first_rsp_seen", imem_rsp_valid, 1);
        tick();
        check_eq("first_out_valid", out_valid, 1);
        check_eq("first_out_pc", out_pc, 0);
        check_eq("first_out_instr", out_instr, 32'h1000_0000);
        for (int i = 0; i < 30 && req_log.size() < 3; i++) tick();
        check_eq("req0", req_at(0), 32'h0);
        check_eq("req1", req_at(1), 32'h4);
        check_eq("req2", req_at(2), 32'h8);

        // Back-pressure: buffer fills, outputs hold, then drain in order
        out_ready = 1'b0;
        do_reset();
        unstable = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid && (out_pc !== 32'h0 || out_instr !== 32'h1000_0000)) unstable++;
        end
        check_eq("bp_req_count", req_log.size(), 2);
        check_eq("bp_buf_count", u_dut.buf_count, 2);
        check_eq("bp_out_valid", out_valid, 1);
        check_eq("bp_req_valid", imem_req_valid, 0);
        check_eq("bp_stable", unstable, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && (out_log.size() < 2 || req_log.size() < 3); i++) tick();
        check_eq("bp_drain0", out_at(0), {32'h0, 32'h1000_0000});
        check_eq("bp_drain1", out_at(1), {32'h4, 32'h1000_0004});
        check_eq("bp_resume", req_at(2), 32'h8);

        // Redirect with two requests in flight
        mem_hold = 1'b1;
        do_reset();
        for (int i = 0; i < 10 && req_log.size() < 2; i++) tick();
        check_eq("rd_outstanding", u_dut.outstanding_q, 2);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        req_log.delete(); out_log.delete();
        check_eq("rd_state_flush", 64'(u_dut.state_q), 64'(ST_FLUSH));
        check_eq("rd_drop", u_dut.drop_q, 2);
        check_eq("rd_pc", imem_req_addr, 32'h100);
        mem_hold = 1'b0;
        flush_req = 0;
        for (int i = 0; i < 30 && out_log.size() < 1; i++) begin
            if (u_dut.state_q == ST_FLUSH && imem_req_valid) flush_req++;
            tick();
        end
        check_eq("rd_no_req_in_flush", flush_req, 0);
        check_eq("rd_first_req", req_at(0), 32'h100);
        check_eq("rd_first_out", out_at(0), {32'h100, 32'h1000_0100});

        // Wrap from the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        req_log.delete(); out_log.delete();
        for (int i = 0; i < 40 && out_log.size() < 2; i++) tick();
        check_eq("wrap_req0", req_at(0), 32'hFFFF_FFFC);
        check_eq("wrap_req1", req_at(1), 32'h0);
        check_eq("wrap_out0", out_at(0), {32'hFFFF_FFFC, 32'h0FFF_FFFC});
        check_eq("wrap_out1", out_at(1), {32'h0, 32'h1000_0000});

        // Reset with a full buffer
        out_ready = 1'b0;
        repeat (10) tick();
        check_eq("mr_buf_full", u_dut.buf_count, 2);
        rst = 1'b1;
        tick();
        check_eq("mr_out_valid", out_valid, 0);
        check_eq("mr_req_valid", imem_req_valid, 0);
        check_eq("mr_pc", imem_req_addr, 32'h0);
        check_eq("mr_out_instr", out_instr, 32'h0000_0013);
        check_eq("mr_outstanding", u_dut.outstanding_q, 0);
        rst = 1'b0; out_ready = 1'b1;
        req_log.delete(); out_log.delete();
        for (int i = 0; i < 30 && out_log.size() < 1; i++) tick();
        check_eq("mr_first_out", out_at(0), {32'h0, 32'h1000_0000});

        // Redirect coinciding with a response and a pop (DEPTH=3 instance)
        d3_rst = 1'b0;
        check_eq("d3_boot_no_req", d3_req_valid, 0);
        tick();
        check_eq("d3_first_addr", d3_req_addr, 32'h200);
        repeat (3) tick();
        check_eq("d3_outstanding", u_dut3.outstanding_q, 3);
        check_eq("d3_req_stall", d3_req_valid, 0);
        d3_rsp_valid = 1'b1; d3_rsp_data = 32'hAAAA_0200;
        tick();
        d3_rsp_valid = 1'b0;
        check_eq("d3_out_valid", d3_out_valid, 1);
        check_eq("d3_out_pc", d3_out_pc, 32'h200);
        check_eq("d3_out_instr", d3_out_instr, 32'hAAAA_0200);
        d3_rsp_valid = 1'b1; d3_rsp_data = 32'hAAAA_0204;
        d3_redirect_valid = 1'b1; d3_redirect_pc = 32'h0000_0404;
        tick();
        d3_rsp_valid = 1'b0; d3_redirect_valid = 1'b0;
        check_eq("d3_pop_count", d3_pop_log.size(), 1);
        check_eq("d3_pop_pc", (d3_pop_log.size() > 0) ? d3_pop_log[0] : 32'hDEAD_BEEF, 32'h200);
        check_eq("d3_rsp_dropped", d3_out_valid, 0);
        check_eq("d3_drop", u_dut3.drop_q, 1);
        check_eq("d3_state_flush", 64'(u_dut3.state_q), 64'(ST_FLUSH));
        check_eq("d3_flush_no_req", d3_req_valid, 0);
        d3_rsp_valid = 1'b1; d3_rsp_data = 32'hAAAA_0208;
        tick();
        d3_rsp_valid = 1'b0;
        check_eq("d3_state_fetch", 64'(u_dut3.state_q), 64'(ST_FETCH));
        check_eq("d3_resume_valid", d3_req_valid, 1);
        check_eq("d3_resume_addr", d3_req_addr, 32'h404);
        check_eq("d3_stale_dropped", d3_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
